// File: rtl/modbus_frame_ctrl_if.sv
// Byte-receiver handshake and frame-result bus between rx_module, the frame
// controller and LED_Display.
interface modbus_frame_ctrl_if;
  logic        RX_Done_Sig;
  logic [7:0]  RX_Data;
  logic        RX_En_Sig;
  logic        Frame_Done;
  logic        Frame_Ok;
  logic [1:0]  Err_Code;
  logic [39:0] Frame_Data;
  logic [7:0]  Frame_Cnt;
  logic [7:0]  Disp_Data;

  modport slave (
    input  RX_Done_Sig, RX_Data,
    output RX_En_Sig, Frame_Done, Frame_Ok, Err_Code, Frame_Data, Frame_Cnt, Disp_Data
  );

  modport master (
    output RX_Done_Sig, RX_Data,
    input  RX_En_Sig, Frame_Done, Frame_Ok, Err_Code, Frame_Data, Frame_Cnt, Disp_Data
  );
endinterface

// File: rtl/modbus_frame_ctrl.sv
// Modbus RTU frame assembler: bit-serial CRC-16/Modbus, inter-byte gap timeout,
// slave-address filter, and publication of the last good frame.
module modbus_frame_ctrl #(
  parameter int unsigned FRAME_LEN  = 7,
  parameter int unsigned GAP_CYCLES = 175000,
  parameter logic [7:0]  SLAVE_ADDR = 8'h01
) (
  input  logic               CLK,
  input  logic               RST,
  modbus_frame_ctrl_if.slave bus
);

  localparam int unsigned GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam int unsigned HDR_LEN  = FRAME_LEN - 2;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CRC, S_CHECK, S_REPORT} state_t;

  state_t             state, state_nx;
  logic [7:0]         byte_q, byte_q_nx;
  logic [15:0]        crc, crc_nx;
  logic [2:0]         bit_cnt, bit_cnt_nx;
  logic [2:0]         byte_cnt, byte_cnt_nx;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_nx;
  logic [39:0]        frame_sr, frame_sr_nx;
  logic               rx_en, rx_en_nx;
  logic               frame_done, frame_done_nx;
  logic               frame_ok, frame_ok_nx;
  logic [1:0]         err_code, err_code_nx;
  logic [39:0]        frame_data, frame_data_nx;
  logic [7:0]         frame_cnt, frame_cnt_nx;
  logic [7:0]         disp_data, disp_data_nx;

  logic               accept, timeout, last_bit, more_bytes, store_byte, addr_ok;
  logic [15:0]        crc_in, crc_step;

  assign accept     = (state == S_WAIT) && bus.RX_Done_Sig;
  assign timeout    = (state == S_WAIT) && !bus.RX_Done_Sig && (byte_cnt != 3'd0)
                      && (gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign last_bit   = (bit_cnt == 3'd7);
  assign more_bytes = (32'(byte_cnt) + 32'd1) < FRAME_LEN;
  assign store_byte = 32'(byte_cnt) < HDR_LEN;
  assign addr_ok    = (frame_sr[39:32] == SLAVE_ADDR) || (frame_sr[39:32] == 8'h00);

  // The byte is folded into the CRC on the first of its eight bit steps.
  assign crc_in   = (bit_cnt == 3'd0) ? (crc ^ {8'h00, byte_q}) : crc;
  assign crc_step = crc_in[0] ? ((crc_in >> 1) ^ CRC_POLY) : (crc_in >> 1);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = S_WAIT;
      S_WAIT:   if (accept)       state_nx = S_CRC;
                else if (timeout) state_nx = S_REPORT;
      S_CRC:    if (last_bit)     state_nx = more_bytes ? S_WAIT : S_CHECK;
      S_CHECK:  state_nx = S_REPORT;
      S_REPORT: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    byte_q_nx     = byte_q;
    crc_nx        = crc;
    bit_cnt_nx    = bit_cnt;
    byte_cnt_nx   = byte_cnt;
    gap_cnt_nx    = gap_cnt;
    frame_sr_nx   = frame_sr;
    frame_done_nx = 1'b0;
    frame_ok_nx   = frame_ok;
    err_code_nx   = err_code;
    frame_data_nx = frame_data;
    frame_cnt_nx  = frame_cnt;
    disp_data_nx  = disp_data;
    rx_en_nx      = (state_nx == S_IDLE) || (state_nx == S_WAIT);

    case (state)
      S_WAIT: begin
        // The accepting cycle is the first cycle of the new silent interval.
        if (accept) begin
          byte_q_nx  = bus.RX_Data;
          gap_cnt_nx = GAP_W'(1);
        end else if (byte_cnt != 3'd0) begin
          gap_cnt_nx = gap_cnt + GAP_W'(1);
        end
        if (timeout) begin
          frame_done_nx = 1'b1;
          frame_ok_nx   = 1'b0;
          err_code_nx   = 2'b10;
        end
      end
      S_CRC: begin
        crc_nx     = crc_step;
        bit_cnt_nx = bit_cnt + 3'd1;
        gap_cnt_nx = gap_cnt + GAP_W'(1);
        if ((bit_cnt == 3'd0) && store_byte) frame_sr_nx = {frame_sr[31:0], byte_q};
        if (last_bit && more_bytes)          byte_cnt_nx = byte_cnt + 3'd1;
      end
      S_CHECK: begin
        frame_done_nx = 1'b1;
        if (crc != 16'h0000) begin
          frame_ok_nx = 1'b0;
          err_code_nx = 2'b01;
        end else if (!addr_ok) begin
          frame_ok_nx = 1'b0;
          err_code_nx = 2'b11;
        end else begin
          frame_ok_nx   = 1'b1;
          err_code_nx   = 2'b00;
          frame_data_nx = frame_sr;
          disp_data_nx  = frame_sr[7:0];
          frame_cnt_nx  = frame_cnt + 8'd1;
        end
      end
      S_REPORT: begin
        crc_nx      = CRC_INIT;
        bit_cnt_nx  = 3'd0;
        byte_cnt_nx = 3'd0;
        gap_cnt_nx  = '0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      byte_q     <= 8'h00;
      crc        <= CRC_INIT;
      bit_cnt    <= 3'd0;
      byte_cnt   <= 3'd0;
      gap_cnt    <= '0;
      frame_sr   <= 40'h0;
      rx_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_code   <= 2'b00;
      frame_data <= 40'h0;
      frame_cnt  <= 8'h00;
      disp_data  <= 8'h00;
    end else begin
      byte_q     <= byte_q_nx;
      crc        <= crc_nx;
      bit_cnt    <= bit_cnt_nx;
      byte_cnt   <= byte_cnt_nx;
      gap_cnt    <= gap_cnt_nx;
      frame_sr   <= frame_sr_nx;
      rx_en      <= rx_en_nx;
      frame_done <= frame_done_nx;
      frame_ok   <= frame_ok_nx;
      err_code   <= err_code_nx;
      frame_data <= frame_data_nx;
      frame_cnt  <= frame_cnt_nx;
      disp_data  <= disp_data_nx;
    end
  end

  assign bus.RX_En_Sig  = rx_en;
  assign bus.Frame_Done = frame_done;
  assign bus.Frame_Ok   = frame_ok;
  assign bus.Err_Code   = err_code;
  assign bus.Frame_Data = frame_data;
  assign bus.Frame_Cnt  = frame_cnt;
  assign bus.Disp_Data  = disp_data;

endmodule

// File: tb/tb_modbus_frame_ctrl.sv
// Randomized bench for modbus_frame_ctrl against a frame-level reference model.
module tb_modbus_frame_ctrl;

  localparam int unsigned GAP  = 40;
  localparam int unsigned FLEN = 7;

  logic clk;
  logic rst;

  modbus_frame_ctrl_if bus ();

  modbus_frame_ctrl #(
    .FRAME_LEN (FLEN),
    .GAP_CYCLES(GAP),
    .SLAVE_ADDR(8'h01)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  logic [7:0]  tx [FLEN];
  logic [39:0] m_data;
  logic [7:0]  m_disp;
  logic [7:0]  m_cnt;
  logic        m_ok;
  logic [1:0]  m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Textbook CRC-16/Modbus over tx[0..n-1]
  function automatic logic [15:0] crc_of(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {8'h00, tx[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic make_frame(input logic [7:0] a, input logic [7:0] f,
                            input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
    logic [15:0] c;
    tx[0] = a; tx[1] = f; tx[2] = p0; tx[3] = p1; tx[4] = p2;
    c = crc_of(5);
    tx[5] = c[7:0];
    tx[6] = c[15:8];
  endtask

  // Frame-level rules: trailing CRC must match the header CRC, then address filter.
  task automatic model_frame();
    logic [15:0] c;
    c = crc_of(5);
    if ({tx[6], tx[5]} != c) begin
      m_ok = 1'b0; m_err = 2'b01;
    end else if (tx[0] != 8'h01 && tx[0] != 8'h00) begin
      m_ok = 1'b0; m_err = 2'b11;
    end else begin
      m_ok   = 1'b1; m_err = 2'b00;
      m_data = {tx[0], tx[1], tx[2], tx[3], tx[4]};
      m_disp = tx[4];
      m_cnt  = m_cnt + 8'd1;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_ok"},   64'(bus.Frame_Ok),   64'(m_ok));
    check({tag, "_err"},  64'(bus.Err_Code),   64'(m_err));
    check({tag, "_data"}, 64'(bus.Frame_Data), 64'(m_data));
    check({tag, "_disp"}, 64'(bus.Disp_Data),  64'(m_disp));
    check({tag, "_cnt"},  64'(bus.Frame_Cnt),  64'(m_cnt));
  endtask

  // Deliver one byte once reception is enabled; returns at cycle 9 after it is sampled.
  task automatic put_byte(input logic [7:0] b, input bit last, input bit junk);
    int w;
    w = 0;
    while (bus.RX_En_Sig !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("rx_en_wait", 64'(w < 300), 64'd1);
    repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    bus.RX_Data     = b;
    bus.RX_Done_Sig = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("rx_en_low", 64'(bus.RX_En_Sig), 64'd0);
      bus.RX_Done_Sig = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.RX_Data     = junk ? 8'($urandom) : b;
    end
    @(negedge clk);
    bus.RX_Done_Sig = 1'b0;
    check("rx_en_c9", 64'(bus.RX_En_Sig), 64'(!last));
    if (last) check("done_c9", 64'(bus.Frame_Done), 64'd0);
  endtask

  task automatic send_frame(input bit junk);
    for (int i = 0; i < FLEN; i++) put_byte(tx[i], (i == FLEN - 1), junk);
    @(negedge clk);
    model_frame();
    check("done_c10", 64'(bus.Frame_Done), 64'd1);
    check_outputs("frame");
    @(negedge clk);
    check("done_c11", 64'(bus.Frame_Done), 64'd0);
    check("rx_en_c11", 64'(bus.RX_En_Sig), 64'd1);
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.Frame_Done === 1'b1) pulses++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"},   64'(bus.RX_En_Sig),  64'd0);
    check({tag, "_done"}, 64'(bus.Frame_Done), 64'd0);
    check({tag, "_ok"},   64'(bus.Frame_Ok),   64'd0);
    check({tag, "_err"},  64'(bus.Err_Code),   64'd0);
    check({tag, "_data"}, 64'(bus.Frame_Data), 64'd0);
    check({tag, "_disp"}, 64'(bus.Disp_Data),  64'd0);
    check({tag, "_cnt"},  64'(bus.Frame_Cnt),  64'd0);
  endtask

  initial begin
    int p;
    int pulses;
    logic [7:0] a;
    n_cmp = 0; n_bad = 0;
    m_data = '0; m_disp = '0; m_cnt = '0; m_ok = 1'b0; m_err = 2'b00;
    rst = 1'b1;
    bus.RX_Done_Sig = 1'b0;
    bus.RX_Data     = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Idle line: no timeout without a partial frame
    count_pulses(3 * GAP, pulses);
    check("idle_no_timeout", 64'(pulses), 64'd0);

    // T1 good frame
    make_frame(8'h01, 8'h06, 8'h12, 8'h34, 8'h56);
    send_frame(1'b0);
    check("t1_data", 64'(bus.Frame_Data), 64'h0106123456);
    check("t1_disp", 64'(bus.Disp_Data),  64'h56);
    check("t1_cnt",  64'(bus.Frame_Cnt),  64'd1);

    // T2 CRC error, published data held
    make_frame(8'h01, 8'h06, 8'h12, 8'h34, 8'h56);
    tx[6] = tx[6] ^ 8'h01;
    send_frame(1'b0);
    check("t2_err", 64'(bus.Err_Code), 64'd1);

    // T3 foreign address rejected, broadcast accepted
    make_frame(8'h05, 8'h03, 8'hA0, 8'h0B, 8'hC3);
    send_frame(1'b0);
    check("t3_err", 64'(bus.Err_Code), 64'd3);
    make_frame(8'h00, 8'h03, 8'hA0, 8'h0B, 8'hC3);
    send_frame(1'b0);
    check("t3_bcast_ok", 64'(bus.Frame_Ok), 64'd1);

    // T4 gap timeout after three bytes
    make_frame(8'h01, 8'h10, 8'h77, 8'h88, 8'h99);
    for (int i = 0; i < 3; i++) put_byte(tx[i], 1'b0, 1'b0);
    p = 9;
    while (bus.Frame_Done !== 1'b1 && p < int'(GAP) + 20) begin
      @(negedge clk);
      p++;
    end
    m_ok = 1'b0; m_err = 2'b10;
    check("gap_cycle", 64'(p), 64'(GAP));
    check_outputs("gap");
    make_frame(8'h01, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    send_frame(1'b0);

    // T5 stray RX_Done_Sig pulses while reception is disabled
    make_frame(8'h01, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    send_frame(1'b1);

    // Random mix of good, corrupted and foreign frames
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0:       a = 8'h00;
        1:       a = 8'h05;
        2:       a = 8'($urandom);
        default: a = 8'h01;
      endcase
      make_frame(a, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        p = $urandom_range(0, FLEN - 1);
        tx[p] = tx[p] ^ (8'h01 << $urandom_range(0, 7));
      end
      send_frame(1'($urandom_range(0, 1)));
    end

    // T6 async reset mid-frame, then counter wrap
    make_frame(8'h01, 8'h06, 8'h01, 8'h02, 8'h03);
    for (int i = 0; i < 3; i++) put_byte(tx[i], 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    m_data = '0; m_disp = '0; m_cnt = '0; m_ok = 1'b0; m_err = 2'b00;
    count_pulses(2 * GAP, pulses);
    check("reset_discard", 64'(pulses), 64'd0);
    for (int n = 0; n < 256; n++) begin
      make_frame(8'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      send_frame(1'b0);
    end
    check("cnt_wrap", 64'(bus.Frame_Cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
